// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths and the "no producer" tag.
// Used by the register file, reservation stations and CDB arbiter.
package tomasulo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TAG_W_DEF  = 2;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/tomasulo_reg_file_rf_entry.sv
// One register: value plus producer tag, with CDB capture and rename.
// State changes on the falling clock edge.
module rf_entry
  import tomasulo_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              TAG_W     = TAG_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  qi_cdb,
  input  logic [DATA_W-1:0] cdb,
  input  logic              issue_hit,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic [DATA_W-1:0] val_o,
  output logic [TAG_W-1:0]  qi_o,
  output logic [TAG_W-1:0]  qi_nxt_o,
  output logic              match_o
);

  logic [DATA_W-1:0] val_q, val_d;
  logic [TAG_W-1:0]  qi_q, qi_d;
  logic              match;

  // cdb_en already excludes tag 0, so an idle entry never matches
  assign match = cdb_en && (qi_q == qi_cdb);

  always_comb begin
    val_d = val_q;
    qi_d  = qi_q;
    if (flush) begin
      qi_d = '0;
    end else begin
      if (match) begin
        val_d = cdb;
        qi_d  = '0;
      end
      // a fresh rename outranks the clear from the same-cycle broadcast
      if (issue_hit) begin
        qi_d = issue_tag;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      val_q <= RESET_VAL;
      qi_q  <= '0;
    end else begin
      val_q <= val_d;
      qi_q  <= qi_d;
    end
  end

  assign val_o    = val_q;
  assign qi_o     = qi_q;
  assign qi_nxt_o = qi_d;
  assign match_o  = match;

endmodule

// File: rtl/tomasulo_reg_file.sv
// Register file with Qi status tags, two bypassed read ports
// and a registered count of renamed (busy) registers.
module tomasulo_reg_file
  import tomasulo_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                NREGS     = 8,
  parameter int                TAG_W     = TAG_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(1),
  localparam int               AW        = $clog2(NREGS),
  localparam int               BW        = $clog2(NREGS + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Issue_en,
  input  logic [AW-1:0]     Issue_rd,
  input  logic [TAG_W-1:0]  Issue_tag,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  Qi_CDB,
  input  logic [DATA_W-1:0] CDB,
  input  logic [AW-1:0]     Rs_addr,
  input  logic [AW-1:0]     Rt_addr,
  output logic [DATA_W-1:0] Rs_val,
  output logic [DATA_W-1:0] Rt_val,
  output logic [TAG_W-1:0]  Rs_qi,
  output logic [TAG_W-1:0]  Rt_qi,
  output logic [BW-1:0]     Busy_count
);

  logic              cdb_en;
  logic              issue_ok;
  logic [NREGS-1:0]  issue_hit;
  logic [NREGS-1:0]  match;
  logic [DATA_W-1:0] ent_val [NREGS];
  logic [TAG_W-1:0]  ent_qi  [NREGS];
  logic [TAG_W-1:0]  ent_nxt [NREGS];
  logic [BW-1:0]     busy_count_q, busy_count_d;

  assign cdb_en   = CDB_valid && (Qi_CDB != TAG_W'(TAG_NONE));
  assign issue_ok = Issue_en && (Issue_tag != TAG_W'(TAG_NONE));

  always_comb begin
    issue_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      issue_hit[i] = issue_ok && (Issue_rd == AW'(i));
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_ent
    rf_entry #(
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W),
      .RESET_VAL (RESET_VAL)
    ) u_ent (
      .clk       (Clock),
      .rst       (Reset),
      .flush     (Flush),
      .cdb_en    (cdb_en),
      .qi_cdb    (Qi_CDB),
      .cdb       (CDB),
      .issue_hit (issue_hit[g]),
      .issue_tag (Issue_tag),
      .val_o     (ent_val[g]),
      .qi_o      (ent_qi[g]),
      .qi_nxt_o  (ent_nxt[g]),
      .match_o   (match[g])
    );
  end

  // Reads see pre-edge state; a matching broadcast is forwarded
  always_comb begin
    Rs_val = '0;
    Rs_qi  = '0;
    Rt_val = '0;
    Rt_qi  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (Rs_addr == AW'(i)) begin
        Rs_val = match[i] ? CDB : ent_val[i];
        Rs_qi  = match[i] ? '0  : ent_qi[i];
      end
      if (Rt_addr == AW'(i)) begin
        Rt_val = match[i] ? CDB : ent_val[i];
        Rt_qi  = match[i] ? '0  : ent_qi[i];
      end
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d
                   + BW'(ent_nxt[i] != '0);
    end
  end

  always_ff @(negedge Clock) begin
    if (Reset) begin
      busy_count_q <= '0;
    end else begin
      busy_count_q <= busy_count_d;
    end
  end

  assign Busy_count = busy_count_q;

endmodule

// File: tb/tb_tomasulo_reg_file.sv
// Scoreboard bench for tomasulo_reg_file: directed plan cases
// followed by randomized traffic against an array-based model.
module tb_tomasulo_reg_file;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int TW = 2;

  logic          Clock;
  logic          Reset;
  logic          Flush;
  logic          Issue_en;
  logic [2:0]    Issue_rd;
  logic [TW-1:0] Issue_tag;
  logic          CDB_valid;
  logic [TW-1:0] Qi_CDB;
  logic [DW-1:0] CDB;
  logic [2:0]    Rs_addr;
  logic [2:0]    Rt_addr;
  logic [DW-1:0] Rs_val;
  logic [DW-1:0] Rt_val;
  logic [TW-1:0] Rs_qi;
  logic [TW-1:0] Rt_qi;
  logic [3:0]    Busy_count;

  tomasulo_reg_file dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Flush      (Flush),
    .Issue_en   (Issue_en),
    .Issue_rd   (Issue_rd),
    .Issue_tag  (Issue_tag),
    .CDB_valid  (CDB_valid),
    .Qi_CDB     (Qi_CDB),
    .CDB        (CDB),
    .Rs_addr    (Rs_addr),
    .Rt_addr    (Rt_addr),
    .Rs_val     (Rs_val),
    .Rt_val     (Rt_val),
    .Rs_qi      (Rs_qi),
    .Rt_qi      (Rt_qi),
    .Busy_count (Busy_count)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [DW-1:0] rsv;
    logic [TW-1:0] rsq;
    logic [DW-1:0] rtv;
    logic [TW-1:0] rtq;
    logic [3:0]    busy;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int miscompares;
  bit model_live;

  int m_val [NR];
  int m_qi  [NR];

  function automatic int m_busy();
    int n = 0;
    foreach (m_qi[i]) if (m_qi[i] != 0) n++;
    return n;
  endfunction

  task automatic step(input bit rst, input bit fl,
                      input bit ie, input int ird, input int itag,
                      input bit cv, input int ctag, input int cval,
                      input int rs, input int rt);
    exp_t e;
    @(posedge Clock);
    Reset     = rst;
    Flush     = fl;
    Issue_en  = ie;
    Issue_rd  = 3'(ird);
    Issue_tag = TW'(itag);
    CDB_valid = cv;
    Qi_CDB    = TW'(ctag);
    CDB       = DW'(cval);
    Rs_addr   = 3'(rs);
    Rt_addr   = 3'(rt);
    if (model_live) begin
      // read port: a live broadcast for the tag being waited on forwards
      if (cv && ctag != 0 && m_qi[rs] == ctag) begin
        e.rsv = DW'(cval); e.rsq = '0;
      end else begin
        e.rsv = DW'(m_val[rs]); e.rsq = TW'(m_qi[rs]);
      end
      if (cv && ctag != 0 && m_qi[rt] == ctag) begin
        e.rtv = DW'(cval); e.rtq = '0;
      end else begin
        e.rtv = DW'(m_val[rt]); e.rtq = TW'(m_qi[rt]);
      end
      e.busy = 4'(m_busy());
      exp_q.push_back(e);
    end
    if (rst) begin
      foreach (m_val[i]) begin m_val[i] = 1; m_qi[i] = 0; end
      model_live = 1;
    end else if (fl) begin
      foreach (m_qi[i]) m_qi[i] = 0;
    end else begin
      if (cv && ctag != 0) begin
        foreach (m_qi[i]) begin
          if (m_qi[i] == ctag) begin
            m_val[i] = cval; m_qi[i] = 0;
          end
        end
      end
      if (ie && itag != 0 && ird < NR) m_qi[ird] = itag;
    end
  endtask

  task automatic idle(input int rs, input int rt);
    step(0, 0, 0, 0, 0, 0, 0, 0, rs, rt);
  endtask

  task automatic issue(input int rd, input int tag);
    step(0, 0, 1, rd, tag, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  // Monitor: every posedge with a pending expectation, compare settled outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if ($isunknown({Rs_val, Rs_qi, Rt_val, Rt_qi, Busy_count})) begin
          vectors++;
          miscompares++;
          $display("FAIL xcheck: outputs unknown at %0t", $time);
        end else begin
          chk("rs_val", int'(Rs_val), int'(e.rsv));
          chk("rs_qi",  int'(Rs_qi),  int'(e.rsq));
          chk("rt_val", int'(Rt_val), int'(e.rtv));
          chk("rt_qi",  int'(Rt_qi),  int'(e.rtq));
          chk("busy",   int'(Busy_count), int'(e.busy));
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_live  = 0;
    Reset = 1; Flush = 0; Issue_en = 0; Issue_rd = '0; Issue_tag = '0;
    CDB_valid = 0; Qi_CDB = '0; CDB = '0; Rs_addr = '0; Rt_addr = '0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 7);
    idle(3, 5);

    // issue then CDB, including read-before-rename on the issue cycle
    step(0, 0, 1, 3, 2, 0, 0, 0, 3, 3);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 1, 2, 'h00AB, 3, 1);
    idle(3, 3);

    // multi-match broadcast; tag-1 holder stays put
    issue(1, 3);
    issue(5, 3);
    issue(6, 1);
    step(0, 0, 0, 0, 0, 1, 3, 'h1234, 1, 5);
    idle(1, 5);
    idle(6, 6);

    // collision: broadcast value lands, new rename tag wins
    issue(2, 1);
    step(0, 0, 1, 2, 3, 1, 1, 'h0055, 2, 6);
    idle(2, 6);

    // same-cycle bypass
    issue(4, 2);
    step(0, 0, 0, 0, 0, 1, 2, 'hBEEF, 4, 2);
    idle(4, 2);

    // flush keeps values, clears tags
    issue(0, 1);
    issue(7, 2);
    step(0, 1, 1, 3, 2, 1, 3, 'h7777, 0, 7);
    idle(0, 2);
    idle(7, 4);

    // tag 0 broadcast must not touch ready registers
    step(0, 0, 0, 0, 0, 1, 0, 'hFFFF, 0, 1);
    idle(0, 1);

    // mid-operation reset drops pending tags
    issue(3, 1);
    issue(5, 2);
    step(1, 0, 1, 6, 3, 1, 1, 'h4444, 3, 5);
    idle(3, 6);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(63) == 0,
           $urandom_range(15) == 0,
           $urandom_range(1),
           $urandom_range(NR - 1),
           $urandom_range(3),
           $urandom_range(2) != 0,
           $urandom_range(3),
           $urandom_range(16'hFFFF),
           $urandom_range(NR - 1),
           $urandom_range(NR - 1));
    end

    repeat (3) @(posedge Clock);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
